// File: rtl/bs_result_logger.sv
// bs_result_logger: captures per-channel kernel results on their done pulses, timestamps them,
// and writes them round-robin as tagged records through a single registered BRAM write port.
module bs_result_logger #(
    parameter int N_CH   = 4,
    parameter int RES_W  = 64,
    parameter int TS_W   = 32,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048,
    parameter int BRAM_W = 192,
    parameter int WRAP   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  round_reset,
    input  logic [N_CH-1:0]       bs_done,
    input  logic [N_CH*RES_W-1:0] ap_return,
    input  logic [TS_W-1:0]       clocks,
    output logic [BRAM_W-1:0]     data_b,
    output logic [ADDR_W-1:0]     addr_b,
    output logic                  we_b,
    output logic [ADDR_W:0]       wr_count,
    output logic                  full,
    output logic                  wrapped,
    output logic [N_CH-1:0]       overflow,
    output logic [15:0]           drop_count
);
    localparam int                CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int                DW        = 6;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic              WRAP_EN   = (WRAP != 0);

    function automatic logic [BRAM_W-1:0] build_record(
        input logic [RES_W-1:0] res,
        input logic [CH_W-1:0]  chan,
        input logic             drop_flag,
        input logic             wrap_flag,
        input logic [15:0]      seq,
        input logic [TS_W-1:0]  ts
    );
        logic [BRAM_W-1:0] rec;
        rec                      = '0;
        rec[RES_W-1:0]           = res;
        rec[RES_W+7:RES_W]       = 8'(chan);
        rec[RES_W+8]             = drop_flag;
        rec[RES_W+9]             = wrap_flag;
        rec[RES_W+31:RES_W+16]   = seq;
        rec[RES_W+32 +: TS_W]    = ts;
        return rec;
    endfunction

    logic [N_CH-1:0]   pend_q, pend_d;
    logic [N_CH-1:0]   dflag_q, dflag_d;
    logic [RES_W-1:0]  res_q [N_CH];
    logic [RES_W-1:0]  res_d [N_CH];
    logic [TS_W-1:0]   ts_q [N_CH];
    logic [TS_W-1:0]   ts_d [N_CH];
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       seq_q, seq_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              full_q, full_d;
    logic              wrapped_q, wrapped_d;
    logic [N_CH-1:0]   ovf_q, ovf_d;
    logic [15:0]       drops_q, drops_d;
    logic [BRAM_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic              we_q, we_d;

    logic              gnt_vld_s;
    logic [CH_W-1:0]   gnt_idx_s;
    logic [N_CH-1:0]   gnt_oh_s;
    logic [CH_W:0]     rr_sum_s;
    logic [CH_W-1:0]   rr_idx_s;
    logic [DW-1:0]     drop_inc_s;
    logic [16:0]       drop_sum_s;

    // Round-robin arbiter: first pending slot at or after the pointer; no grants once full.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        rr_sum_s  = '0;
        rr_idx_s  = '0;
        for (int k = 0; k < N_CH; k++) begin
            rr_sum_s = {1'b0, ptr_q} + (CH_W + 1)'(k);
            rr_sum_s = (rr_sum_s >= (CH_W + 1)'(N_CH)) ? rr_sum_s - (CH_W + 1)'(N_CH) : rr_sum_s;
            rr_idx_s = rr_sum_s[CH_W-1:0];
            if (!gnt_vld_s && !full_q && pend_q[rr_idx_s]) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = rr_idx_s;
            end else begin
                gnt_vld_s = gnt_vld_s;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            gnt_oh_s[i] = gnt_vld_s && (gnt_idx_s == CH_W'(i));
        end
    end

    // Slot capture and drop accounting; a slot granted this cycle may accept a new result.
    always_comb begin
        pend_d     = pend_q;
        dflag_d    = dflag_q & ~gnt_oh_s;
        ovf_d      = ovf_q;
        res_d      = res_q;
        ts_d       = ts_q;
        drop_inc_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (full_q) begin
                // Full: everything still waiting and every new result is discarded.
                ovf_d[i]   = ovf_q[i] | pend_q[i] | bs_done[i];
                drop_inc_s = drop_inc_s + DW'(pend_q[i]) + DW'(bs_done[i]);
                pend_d[i]  = 1'b0;
            end else if (bs_done[i]) begin
                if (pend_q[i] && !gnt_oh_s[i]) begin
                    ovf_d[i]   = 1'b1;
                    dflag_d[i] = 1'b1;
                    drop_inc_s = drop_inc_s + DW'(1);
                end else begin
                    pend_d[i] = 1'b1;
                    res_d[i]  = ap_return[i*RES_W +: RES_W];
                    ts_d[i]   = clocks;
                end
            end else begin
                pend_d[i] = pend_q[i] & ~gnt_oh_s[i];
            end
        end
        drop_sum_s = {1'b0, drops_q} + 17'(drop_inc_s);
        drops_d    = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
        if (round_reset) begin
            pend_d  = '0;
            dflag_d = '0;
            ovf_d   = '0;
            drops_d = '0;
        end else begin
            drops_d = drops_d;
        end
    end

    // Write path: record assembly, address/sequence/count bookkeeping and wrap/full status.
    always_comb begin
        we_d      = gnt_vld_s;
        data_d    = data_q;
        addr_b_d  = addr_b_q;
        addr_d    = addr_q;
        seq_d     = seq_q;
        cnt_d     = cnt_q;
        full_d    = full_q;
        wrapped_d = wrapped_q;
        ptr_d     = ptr_q;
        if (gnt_vld_s) begin
            data_d   = build_record(res_q[gnt_idx_s], gnt_idx_s, dflag_q[gnt_idx_s],
                                    wrapped_q, seq_q, ts_q[gnt_idx_s]);
            addr_b_d = addr_q;
            seq_d    = seq_q + 16'd1;
            cnt_d    = (cnt_q == DEPTH_CNT) ? cnt_q : cnt_q + (ADDR_W + 1)'(1);
            ptr_d    = (gnt_idx_s == CH_W'(N_CH - 1)) ? '0 : gnt_idx_s + CH_W'(1);
            if (addr_q == LAST_ADDR) begin
                addr_d    = WRAP_EN ? '0 : addr_q;
                wrapped_d = wrapped_q | WRAP_EN;
                full_d    = full_q | ~WRAP_EN;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end else begin
            we_d = 1'b0;
        end
        if (round_reset) begin
            we_d      = 1'b0;
            data_d    = data_q;
            addr_b_d  = addr_b_q;
            addr_d    = '0;
            seq_d     = '0;
            cnt_d     = '0;
            full_d    = 1'b0;
            wrapped_d = 1'b0;
            ptr_d     = '0;
        end else begin
            we_d = we_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q    <= '0;
            dflag_q   <= '0;
            ptr_q     <= '0;
            addr_q    <= '0;
            seq_q     <= '0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            wrapped_q <= 1'b0;
            ovf_q     <= '0;
            drops_q   <= '0;
            data_q    <= '0;
            addr_b_q  <= '0;
            we_q      <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                res_q[i] <= '0;
                ts_q[i]  <= '0;
            end
        end else begin
            pend_q    <= pend_d;
            dflag_q   <= dflag_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            seq_q     <= seq_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            wrapped_q <= wrapped_d;
            ovf_q     <= ovf_d;
            drops_q   <= drops_d;
            data_q    <= data_d;
            addr_b_q  <= addr_b_d;
            we_q      <= we_d;
            for (int i = 0; i < N_CH; i++) begin
                res_q[i] <= res_d[i];
                ts_q[i]  <= ts_d[i];
            end
        end
    end

    assign data_b     = data_q;
    assign addr_b     = addr_b_q;
    assign we_b       = we_q;
    assign wr_count   = cnt_q;
    assign full       = full_q;
    assign wrapped    = wrapped_q;
    assign overflow   = ovf_q;
    assign drop_count = drops_q;

endmodule
